// File: rtl/tag_array_nway.sv
// tag_array_nway: N-way cache tag store with valid bits, single-cycle
// hit/miss compare, per-set round-robin replacement pointer and a
// hardware invalidate sweep after reset or flush.
// Optional feature: define TAG_ARRAY_PARITY_EN to add a per-entry even
// parity bit over the tag; corrupted entries miss, raise par_err and are
// dropped.
module tag_array_nway #(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 32,
  parameter  int TAG_W = 22,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             CK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [WAY_W-1:0] req_way,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic [WAY_W-1:0] rsp_victim,
  output logic             busy,
  output logic             par_err
);

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // Storage is deliberately unreset: valid bits and rr are cleared by the sweep.
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAY_W-1:0] rr_mem    [SETS];
`ifdef TAG_ARRAY_PARITY_EN
  logic [WAYS-1:0]  par_mem   [SETS];
`endif

  logic [WAYS-1:0]  tag_eq, par_bad, match, empty;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way, victim_way;
  logic             accept, lookup_acc, fill_acc, inv_acc, sweep;

  assign busy       = (state_q == INIT);
  assign req_ready  = (state_q == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign lookup_acc = accept && (req_op == 2'b00);
  assign fill_acc   = accept && (req_op == 2'b01);
  assign inv_acc    = accept && (req_op == 2'b10);
  assign sweep      = (state_q == INIT) && !flush;

  // Round-robin successor of a way, wrapping at WAYS.
  function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
    if (WAYS == 1) return '0;
    return (w == WAY_W'(WAYS - 1)) ? '0 : w + 1'b1;
  endfunction

  // Per-way compare against the addressed set.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign tag_eq[gi] = (tag_mem[req_idx][gi] == req_tag);
`ifdef TAG_ARRAY_PARITY_EN
    assign par_bad[gi] = valid_mem[req_idx][gi] &&
                         ((^tag_mem[req_idx][gi]) != par_mem[req_idx][gi]);
`else
    assign par_bad[gi] = 1'b0;
`endif
    assign match[gi] = valid_mem[req_idx][gi] && !par_bad[gi] && tag_eq[gi];
    assign empty[gi] = !valid_mem[req_idx][gi] || par_bad[gi];
  end

  // Lowest hitting way, and victim = lowest empty way else the rr pointer.
  always_comb begin
    hit_any    = |match;
    hit_way    = '0;
    victim_way = rr_mem[req_idx];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) hit_way = WAY_W'(i);
      if (empty[i]) victim_way = WAY_W'(i);
    end
    if (WAYS == 1) begin
      hit_way    = '0;
      victim_way = '0;
    end
  end

  // Next-state logic: flush restarts the sweep, INIT walks every set once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = INIT;
      cnt_d   = '0;
    end else if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(SETS - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Tag/valid/rr array updates from the sweep and accepted requests.
  always_ff @(posedge CK) begin
    if (sweep) begin
      valid_mem[cnt_q] <= '0;
      rr_mem[cnt_q]    <= '0;
    end
    if (fill_acc) begin
      valid_mem[req_idx][req_way] <= 1'b1;
      tag_mem[req_idx][req_way]   <= req_tag;
      rr_mem[req_idx]             <= next_way(req_way);
`ifdef TAG_ARRAY_PARITY_EN
      par_mem[req_idx][req_way]   <= ^req_tag;
`endif
    end
    if (inv_acc) begin
      valid_mem[req_idx][req_way] <= 1'b0;
    end
    if (lookup_acc) begin
      if (hit_any) rr_mem[req_idx] <= next_way(hit_way);
`ifdef TAG_ARRAY_PARITY_EN
      valid_mem[req_idx] <= valid_mem[req_idx] & ~par_bad;
`endif
    end
  end

  // Control state and registered lookup response.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_victim <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= lookup_acc;
      if (lookup_acc) begin
        rsp_hit    <= hit_any;
        rsp_way    <= hit_way;
        rsp_victim <= victim_way;
      end
    end
  end

`ifdef TAG_ARRAY_PARITY_EN
  // Parity error pulse aligned with the lookup response.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) par_err <= 1'b0;
    else       par_err <= lookup_acc && (|par_bad);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_array_nway.sv
// Randomized + directed bench for tag_array_nway against a behavioural
// model of the tag store (arrays of valid/tag, rr per set, busy countdown).
module tb_tag_array_nway;
  localparam int WAYS  = 2;
  localparam int SETS  = 32;
  localparam int TAG_W = 22;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             CK = 1'b0;
  logic             RSTn = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [IDX_W-1:0] req_idx = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [WAY_W-1:0] req_way = '0;
  logic             rsp_valid, rsp_hit, busy, par_err;
  logic [WAY_W-1:0] rsp_way, rsp_victim;

  tag_array_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .CK(CK), .RSTn(RSTn), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready), .req_op(req_op), .req_idx(req_idx),
    .req_tag(req_tag), .req_way(req_way), .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_victim(rsp_victim),
    .busy(busy), .par_err(par_err)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Model state
  bit               mv  [SETS][WAYS];
  logic [TAG_W-1:0] mt  [SETS][WAYS];
  bit               mpb [SETS][WAYS];
  int               mrr [SETS];
  int               m_init;
  bit               e_rv, e_hit, e_pe;
  int               e_way, e_vic;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reset or flush: everything invalid once the sweep completes.
  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w]  = 0;
        mpb[s][w] = 0;
      end
    end
    m_init = SETS;
  endtask

  // Drive one cycle of inputs at a negedge, predict, then check after the edge.
  task automatic step(input bit v, input int op, input int idx,
                      input logic [TAG_W-1:0] tag, input int way, input bit fl);
    bit acc;
    int hw, vic;
    bit hit, pe;
    req_valid = v;
    req_op    = op[1:0];
    req_idx   = idx[IDX_W-1:0];
    req_tag   = tag;
    req_way   = way[WAY_W-1:0];
    flush     = fl;
    #1;
    check("req_ready", req_ready, (m_init == 0) && !fl);
    acc  = 0;
    e_rv = 0;
    e_pe = 0;
    if (fl) model_clear();
    else if (m_init > 0) m_init--;
    else if (v) begin
      acc = 1;
      case (op)
        0: begin
          hit = 0; hw = 0; vic = -1; pe = 0;
          for (int w = 0; w < WAYS; w++) begin
            bit bad;
            bad = mv[idx][w] && mpb[idx][w];
            if (bad) pe = 1;
            if (!hit && mv[idx][w] && !bad && mt[idx][w] == tag) begin
              hit = 1; hw = w;
            end
            if (vic < 0 && (!mv[idx][w] || bad)) vic = w;
          end
          if (vic < 0) vic = mrr[idx];
          if (hit) mrr[idx] = (hw + 1) % WAYS;
          for (int w = 0; w < WAYS; w++)
            if (mv[idx][w] && mpb[idx][w]) begin
              mv[idx][w] = 0; mpb[idx][w] = 0;
            end
          e_rv = 1; e_hit = hit; e_way = hw; e_vic = vic; e_pe = pe;
        end
        1: begin
          mv[idx][way] = 1; mt[idx][way] = tag; mpb[idx][way] = 0;
          mrr[idx] = (way + 1) % WAYS;
        end
        2: mv[idx][way] = 0;
        default: ;
      endcase
    end
    $display("op v=%0d op=%0d idx=%0d tag=%0h way=%0d flush=%0d acc=%0d", v, op, idx, tag, way, fl, acc);
    @(negedge CK);
    check("rsp_valid", rsp_valid, e_rv);
    check("par_err", par_err, e_pe);
    check("busy", busy, m_init > 0);
    if (e_rv) begin
      check("rsp_hit", rsp_hit, e_hit);
      check("rsp_way", rsp_way, e_hit ? e_way : 0);
      check("rsp_victim", rsp_victim, e_vic);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
  endtask

  task automatic lookup(input int idx, input logic [TAG_W-1:0] tag);
    step(1, 0, idx, tag, 0, 0);
  endtask

  logic [TAG_W-1:0] tag_pool [4];
  int busy_cycles;

  initial begin
    tag_pool[0] = 22'h12345;
    tag_pool[1] = 22'h00001;
    tag_pool[2] = 22'h3FFFFF;
    tag_pool[3] = 22'h2AAAA;
    model_clear();
    e_rv = 0;
    e_pe = 0;
    repeat (3) @(negedge CK);
    check("reset_busy", busy, 1);
    check("reset_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_par_err", par_err, 0);
    RSTn = 1'b1;

    // Sweep length: busy must hold for exactly SETS cycles.
    busy_cycles = 0;
    for (int i = 0; i < SETS + 4; i++) begin
      if (busy) busy_cycles++;
      step(1, 0, 1, '0, 0, 0);
    end
    check("sweep_len", busy_cycles, SETS);

    lookup(5, 22'h12345);
    step(1, 1, 5, 22'h0AAAA, 0, 0);
    step(1, 1, 5, 22'h12345, 1, 0);
    lookup(5, 22'h00777);
    lookup(5, 22'h12345);
    step(1, 2, 5, '0, 1, 0);
    lookup(5, 22'h12345);
    step(1, 3, 5, '0, 0, 0);

    step(1, 1, 3, 22'h00003, 0, 0);
    step(1, 1, 4, 22'h00004, 1, 0);
    step(1, 1, 7, 22'h00007, 0, 0);
    lookup(3, 22'h00003);
    lookup(4, 22'h00004);
    lookup(7, 22'h00099);
    step(1, 0, 3, 22'h00003, 0, 1);
    idle(SETS + 2);
    lookup(3, 22'h00003);
    lookup(4, 22'h00004);

    // Flush in the middle of a sweep restarts it.
    step(0, 0, 0, '0, 0, 1);
    idle(10);
    step(0, 0, 0, '0, 0, 1);
    idle(SETS + 1);

`ifdef TAG_ARRAY_PARITY_EN
    step(1, 1, 9, 22'h00F0F, 0, 0);
    dut.tag_mem[9][0] = dut.tag_mem[9][0] ^ 22'h4;
    mpb[9][0] = 1;
    lookup(9, 22'h00F0F);
    lookup(9, 22'h00F0F);
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom % 4, $urandom % 8,
           tag_pool[$urandom % 4], $urandom % WAYS, ($urandom % 100) == 0);
    end

    // Asynchronous reset while a response is on the outputs drops it.
    idle(SETS + 1);
    step(1, 1, 2, 22'h00022, 0, 0);
    lookup(2, 22'h00022);
    RSTn = 1'b0;
    #1;
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_busy", busy, 1);
    check("midreset_ready", req_ready, 0);
    model_clear();
    e_rv = 0;
    @(negedge CK);
    RSTn = 1'b1;
    idle(SETS + 1);
    lookup(2, 22'h00022);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tag_array_nway.md
Name: tag_array_nway

Overview:
- Parametrised N-way cache tag store with valid bits, hit/miss compare, per-set replacement pointer and hardware invalidate sweep.
- Successor to the fixed two-macro tag wrapper; the L1 I/D cache controllers instantiate it in place of hand-wired tag macros.
- Single-issue request/response interface, one operation per cycle, 1-cycle lookup latency.

Parameters:
WAYS, 2, number of ways (power of two, 1..8)
SETS, 32, number of sets (power of two, 2..256)
TAG_W, 22, tag width in bits
IDX_W, $clog2(SETS), index width (derived, not overridden)
WAY_W, (WAYS>1 ? $clog2(WAYS) : 1), way-select width (derived)

Ports:
CK  in  1  clock
RSTn  in  1  asynchronous active-low reset
flush  in  1  pulse: invalidate all entries
req_valid  in  1  request valid
req_ready  out  1  block accepts request this cycle
req_op  in  2  00 lookup, 01 fill, 10 invalidate-line, 11 reserved (treated as no-op, still accepted)
req_idx  in  IDX_W  set index
req_tag  in  TAG_W  tag for lookup/fill
req_way  in  WAY_W  target way for fill/invalidate-line
rsp_valid  out  1  lookup result valid (1-cycle pulse)
rsp_hit  out  1  lookup hit
rsp_way  out  WAY_W  hitting way (0 on miss)
rsp_victim  out  WAY_W  way to replace on miss
busy  out  1  invalidate sweep in progress
par_err  out  1  parity error pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Storage: SETS x WAYS entries {valid, tag}, flop array; plus per-set round-robin pointer rr[set] (WAY_W bits).
- Reset (RSTn low, async): all outputs 0 except busy=1; FSM=INIT, sweep counter=0; rr[] and tag contents not reset, valid cleared only by sweep.
- FSM states: INIT, IDLE.
- INIT: each cycle clears valid for all ways of set cnt and sets rr[cnt]=0; cnt increments; at cnt==SETS-1 go to IDLE the next cycle. Sweep lasts exactly SETS cycles. busy=1, req_ready=0 throughout.
- IDLE: req_ready=1 (combinational, = state==IDLE && !flush). Accept = req_valid && req_ready.
- Lookup accepted at edge t: at t+1 rsp_valid=1 for one cycle; rsp_hit=1 if any way has valid && tag==req_tag; rsp_way = lowest hitting way. Multiple hits are not expected; lowest index wins.
- rsp_victim, computed at the same time: lowest-index invalid way if any, else rr[idx].
- On hit, rr[idx] <= (rsp_way+1) mod WAYS. On miss, rr is unchanged.
- Fill accepted: entry[idx][req_way] <= {1, req_tag}; rr[idx] <= (req_way+1) mod WAYS. Visible to a lookup accepted on the next cycle. No response pulse.
- Invalidate-line accepted: valid[idx][req_way] <= 0; rr unchanged. No response pulse.
- Back-to-back: a new request may be accepted every IDLE cycle, including the cycle rsp_valid is high.
- flush high in any state: next state INIT, cnt <= 0. A request presented in the same cycle is not accepted. flush during INIT restarts the sweep from set 0. A lookup accepted the cycle before flush still produces its rsp_valid.
- WAYS==1: rsp_victim and rsp_way always 0; rr unused.
- Mid-operation reset: outstanding response dropped; rsp_valid forced 0.

Optional Feature:
- Macro TAG_ARRAY_PARITY_EN.
- Defined: each entry stores an even-parity bit over the tag, written on fill. On lookup, a valid way whose parity mismatches is treated as non-matching and as invalid for victim selection. par_err pulses with rsp_valid if any valid way of the set mismatched. The entry is cleared (valid=0) on the cycle of the response.
- Not defined: no parity storage; par_err tied 0.

Test Plan:
- Reset release -> busy=1, req_ready=0 for exactly 32 cycles (SETS=32); then req_ready=1, busy=0.
- Lookup idx=5 tag=0x12345 after init -> rsp_hit=0, rsp_victim=0 one cycle later.
- Fill idx=5 way=1 tag=0x12345, then lookup next cycle -> rsp_hit=1, rsp_way=1; both ways valid with other tags -> victim follows rr (way 0 after the way-1 fill).
- Invalidate-line idx=5 way=1, then lookup tag=0x12345 -> miss, rsp_victim=1.
- Back-to-back lookups on idx 3, 4, 7 -> three consecutive rsp_valid pulses with correct hits. Flush asserted mid-stream -> req_ready=0 for 32 cycles, then all lookups miss.
- With TAG_ARRAY_PARITY_EN: force a tag bit flip in a valid entry, then look it up -> rsp_hit=0, par_err=1; repeat lookup -> par_err=0, victim = that way.
